// File: rtl/rf_pkg.sv
// Shared register-file constants and the address-to-one-hot helper.
// The RTL and the testbench both import this package.
package rf_pkg;

  localparam int unsigned RF_ADR_W = 3;
  localparam int unsigned RF_NREG  = 2 ** RF_ADR_W;

  function automatic logic [RF_NREG-1:0] onehot(input logic [RF_ADR_W-1:0] adr);
    logic [RF_NREG-1:0] v;
    v      = '0;
    v[adr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_busy_scoreboard_onehot_dec.sv
// Combinational address to one-hot decoder with an enable.
// The output is all zeros when i_en is low.
module onehot_dec #(
  parameter int unsigned ADR_W = 3
) (
  input  logic                  i_en,
  input  logic [ADR_W-1:0]      i_adr,
  output logic [(2**ADR_W)-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_adr] = 1'b1;
  end

endmodule

// File: rtl/reg_busy_scoreboard.sv
// Register busy scoreboard with RAW/WAW issue stall and a registered
// one-hot regfile write enable driven by the writeback address.
module reg_busy_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADR_W     = RF_ADR_W,
  parameter bit          ZERO_HARD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic                  iss_wr,
  input  logic [ADR_W-1:0]      iss_dst,
  input  logic                  iss_use_a,
  input  logic [ADR_W-1:0]      iss_src_a,
  input  logic                  iss_use_b,
  input  logic [ADR_W-1:0]      iss_src_b,
  input  logic                  wb_valid,
  input  logic [ADR_W-1:0]      wb_adr,
  output logic [(2**ADR_W)-1:0] wb_loc,
  output logic [(2**ADR_W)-1:0] busy_vec,
  output logic [ADR_W:0]        pend_cnt,
  output logic                  wb_err
);

  localparam int unsigned NREG = 2 ** ADR_W;

  // Register 0 drops out of every set/clear/enable vector when hardwired.
  localparam logic [NREG-1:0] ZMASK = ZERO_HARD ? {{(NREG-1){1'b1}}, 1'b0} : {NREG{1'b1}};

  function automatic logic [ADR_W:0] popcount(input logic [NREG-1:0] v);
    logic [ADR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) cnt = cnt + {{ADR_W{1'b0}}, v[i]};
    return cnt;
  endfunction

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] r_wb_loc;
  logic [ADR_W:0]  r_pend;
  logic            r_wb_err;

  logic [NREG-1:0] w_clr_raw;
  logic [NREG-1:0] w_set_raw;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_eff_busy;
  logic [NREG-1:0] w_busy_d;
  logic            w_raw;
  logic            w_waw;
  logic            w_ready;
  logic            w_accept;
  logic            w_err_hit;

  onehot_dec #(
    .ADR_W (ADR_W)
  ) u_dec_wb (
    .i_en     (wb_valid),
    .i_adr    (wb_adr),
    .o_onehot (w_clr_raw)
  );

  onehot_dec #(
    .ADR_W (ADR_W)
  ) u_dec_dst (
    .i_en     (w_accept & iss_wr),
    .i_adr    (iss_dst),
    .o_onehot (w_set_raw)
  );

  // A writeback in the same cycle releases its register for issue (bypass).
  always_comb begin
    w_clr      = w_clr_raw & ZMASK;
    w_set      = w_set_raw & ZMASK;
    w_eff_busy = r_busy & ~w_clr;
    w_raw      = (iss_use_a & w_eff_busy[iss_src_a]) | (iss_use_b & w_eff_busy[iss_src_b]);
    w_waw      = iss_wr & w_eff_busy[iss_dst];
    w_ready    = ~flush & ~w_raw & ~w_waw;
    w_accept   = iss_valid & w_ready;
    w_busy_d   = flush ? '0 : (w_eff_busy | w_set);
    w_err_hit  = wb_valid & ~r_busy[wb_adr] & ~flush & ~(ZERO_HARD && (wb_adr == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= '0;
      r_wb_loc <= '0;
      r_pend   <= '0;
      r_wb_err <= 1'b0;
    end else begin
      r_busy   <= w_busy_d;
      r_wb_loc <= w_clr;
      r_pend   <= popcount(w_busy_d);
      r_wb_err <= r_wb_err | w_err_hit;
    end
  end

  assign iss_ready = w_ready;
  assign wb_loc    = r_wb_loc;
  assign busy_vec  = r_busy;
  assign pend_cnt  = r_pend;
  assign wb_err    = r_wb_err;

endmodule

// File: tb/tb_reg_busy_scoreboard.sv
// Directed bench for reg_busy_scoreboard: ADR_W=3 plain, ADR_W=3 with a
// hardwired register 0, and ADR_W=5, all on one clock and one reset.
module tb_reg_busy_scoreboard;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // a_: ADR_W=3, z_: ADR_W=3 ZERO_HARD=1, f_: ADR_W=5
  logic       a_flush, a_iv, a_ir, a_wr, a_ua, a_ub, a_wbv, a_err;
  logic [2:0] a_dst, a_sa, a_sb, a_wba;
  logic [7:0] a_loc, a_busy;
  logic [3:0] a_cnt;

  logic       z_flush, z_iv, z_ir, z_wr, z_ua, z_ub, z_wbv, z_err;
  logic [2:0] z_dst, z_sa, z_sb, z_wba;
  logic [7:0] z_loc, z_busy;
  logic [3:0] z_cnt;

  logic        f_flush, f_iv, f_ir, f_wr, f_ua, f_ub, f_wbv, f_err;
  logic [4:0]  f_dst, f_sa, f_sb, f_wba;
  logic [31:0] f_loc, f_busy;
  logic [5:0]  f_cnt;

  reg_busy_scoreboard #(.ADR_W(3), .ZERO_HARD(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .iss_valid(a_iv), .iss_ready(a_ir),
    .iss_wr(a_wr), .iss_dst(a_dst), .iss_use_a(a_ua), .iss_src_a(a_sa), .iss_use_b(a_ub),
    .iss_src_b(a_sb), .wb_valid(a_wbv), .wb_adr(a_wba), .wb_loc(a_loc), .busy_vec(a_busy),
    .pend_cnt(a_cnt), .wb_err(a_err)
  );

  reg_busy_scoreboard #(.ADR_W(3), .ZERO_HARD(1'b1)) u_z (
    .clk(clk), .rst_n(rst_n), .flush(z_flush), .iss_valid(z_iv), .iss_ready(z_ir),
    .iss_wr(z_wr), .iss_dst(z_dst), .iss_use_a(z_ua), .iss_src_a(z_sa), .iss_use_b(z_ub),
    .iss_src_b(z_sb), .wb_valid(z_wbv), .wb_adr(z_wba), .wb_loc(z_loc), .busy_vec(z_busy),
    .pend_cnt(z_cnt), .wb_err(z_err)
  );

  reg_busy_scoreboard #(.ADR_W(5), .ZERO_HARD(1'b0)) u_f (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .iss_valid(f_iv), .iss_ready(f_ir),
    .iss_wr(f_wr), .iss_dst(f_dst), .iss_use_a(f_ua), .iss_src_a(f_sa), .iss_use_b(f_ub),
    .iss_src_b(f_sb), .wb_valid(f_wbv), .wb_adr(f_wba), .wb_loc(f_loc), .busy_vec(f_busy),
    .pend_cnt(f_cnt), .wb_err(f_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    {a_flush, a_iv, a_wr, a_ua, a_ub, a_wbv} = '0;
    {a_dst, a_sa, a_sb, a_wba} = '0;
    {z_flush, z_iv, z_wr, z_ua, z_ub, z_wbv} = '0;
    {z_dst, z_sa, z_sb, z_wba} = '0;
    {f_flush, f_iv, f_wr, f_ua, f_ub, f_wbv} = '0;
    {f_dst, f_sa, f_sb, f_wba} = '0;
  endtask

  initial begin
    // 1. Reset with activity on the inputs
    idle_all();
    a_iv = 1; a_wr = 1; a_dst = 3; a_wbv = 1; a_wba = 2;
    f_iv = 1; f_wr = 1; f_dst = 9; f_wbv = 1; f_wba = 4;
    tick(); tick(); tick();
    check("rst_busy", 64'(a_busy), 64'h0);
    check("rst_loc", 64'(a_loc), 64'h0);
    check("rst_cnt", 64'(a_cnt), 64'h0);
    check("rst_err", 64'(a_err), 64'h0);
    check("rst_busy5", 64'(f_busy), 64'h0);
    idle_all();
    rst_n = 1'b1;
    #1;
    check("rst_ready", 64'(a_ir), 64'h1);

    // 2. RAW stall and writeback bypass
    a_iv = 1; a_wr = 1; a_dst = 3;
    #1 check("raw_first_ready", 64'(a_ir), 64'h1);
    tick();
    check("raw_busy", 64'(a_busy), 64'(onehot(3'd3)));
    check("raw_cnt", 64'(a_cnt), 64'h1);
    a_wr = 0; a_ua = 1; a_sa = 3;
    #1 check("raw_stall", 64'(a_ir), 64'h0);
    tick();
    check("raw_hold", 64'(a_busy), 64'h08);
    a_wbv = 1; a_wba = 3;
    #1 check("raw_bypass", 64'(a_ir), 64'h1);
    tick();
    check("raw_wbloc", 64'(a_loc), 64'h08);
    check("raw_clr", 64'(a_busy), 64'h0);
    check("raw_err", 64'(a_err), 64'h0);
    idle_all();
    tick();
    check("loc_drop", 64'(a_loc), 64'h0);

    // 3. Same-cycle clear and set: set wins
    a_iv = 1; a_wr = 1; a_dst = 5;
    tick();
    check("waw_busy", 64'(a_busy), 64'h20);
    a_wbv = 1; a_wba = 5;
    #1 check("waw_ready", 64'(a_ir), 64'h1);
    tick();
    check("waw_keep", 64'(a_busy), 64'h20);
    check("waw_cnt", 64'(a_cnt), 64'h1);
    check("waw_loc", 64'(a_loc), 64'h20);
    idle_all();
    a_wr = 1; a_dst = 5;
    #1 check("waw_stall", 64'(a_ir), 64'h0);
    idle_all();
    a_wbv = 1; a_wba = 5;
    tick();
    check("waw_drain", 64'(a_busy), 64'h0);

    // 4. Fill every register, then flush
    idle_all();
    for (int i = 0; i < 8; i++) begin
      a_iv = 1; a_wr = 1; a_dst = 3'(i);
      tick();
    end
    check("fill_busy", 64'(a_busy), 64'hFF);
    check("fill_cnt", 64'(a_cnt), 64'h8);
    idle_all();
    a_flush = 1; a_iv = 1; a_wr = 1; a_dst = 2; a_wbv = 1; a_wba = 1;
    #1 check("flush_ready", 64'(a_ir), 64'h0);
    tick();
    check("flush_busy", 64'(a_busy), 64'h0);
    check("flush_cnt", 64'(a_cnt), 64'h0);
    check("flush_loc", 64'(a_loc), 64'h02);
    check("flush_err", 64'(a_err), 64'h0);
    idle_all();

    // 5. Hardwired register 0
    z_iv = 1; z_wr = 1; z_dst = 0;
    #1 check("z_ready", 64'(z_ir), 64'h1);
    tick();
    check("z_busy", 64'(z_busy), 64'h0);
    check("z_cnt", 64'(z_cnt), 64'h0);
    z_wr = 0; z_ua = 1; z_sa = 0;
    #1 check("z_nostall", 64'(z_ir), 64'h1);
    idle_all();
    z_wbv = 1; z_wba = 0;
    tick();
    check("z_loc", 64'(z_loc), 64'h0);
    check("z_err", 64'(z_err), 64'h0);
    z_wba = 4; z_flush = 1;
    tick();
    check("z_flush_err", 64'(z_err), 64'h0);
    check("z_flush_loc", 64'(z_loc), 64'h10);
    idle_all();

    // 6. Sticky writeback error
    a_wbv = 1; a_wba = 6;
    tick();
    check("err_set", 64'(a_err), 64'h1);
    idle_all();
    tick(); tick();
    check("err_sticky", 64'(a_err), 64'h1);

    // ADR_W=5
    f_iv = 1; f_wr = 1; f_dst = 31;
    tick();
    check("f_busy31", 64'(f_busy), 64'h8000_0000);
    check("f_cnt1", 64'(f_cnt), 64'h1);
    f_wr = 0; f_ub = 1; f_sb = 31;
    #1 check("f_stall", 64'(f_ir), 64'h0);
    f_wbv = 1; f_wba = 31;
    #1 check("f_bypass", 64'(f_ir), 64'h1);
    tick();
    check("f_loc31", 64'(f_loc), 64'h8000_0000);
    check("f_clr", 64'(f_busy), 64'h0);
    idle_all();
    for (int i = 0; i < 32; i++) begin
      f_iv = 1; f_wr = 1; f_dst = 5'(i);
      tick();
    end
    check("f_fill", 64'(f_busy), 64'hFFFF_FFFF);
    check("f_cnt32", 64'(f_cnt), 64'd32);
    idle_all();
    f_flush = 1;
    #1 check("f_flush_ready", 64'(f_ir), 64'h0);
    tick();
    check("f_flush_busy", 64'(f_busy), 64'h0);
    check("f_flush_cnt", 64'(f_cnt), 64'h0);
    idle_all();

    // Reset clears the sticky error immediately
    #2 rst_n = 1'b0;
    #1 check("err_reset", 64'(a_err), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("err_after", 64'(a_err), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
